// File: rtl/timer_regressivo_pkg.sv
// timer_regressivo_pkg: shared state encoding and constants for the countdown timer
package timer_regressivo_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SET  = 2'd1,
        RUN  = 2'd2
    } state_t;
    localparam int TICK_DIV_DEFAULT = 100;
    localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/timer_regressivo_bcd_digit_down.sv
// bcd_digit_down: one BCD digit decrement stage with borrow chain and selectable wrap value
module bcd_digit_down
    import timer_regressivo_pkg::*;
#(
    parameter logic [3:0] WRAP = BCD_MAX
) (
    input  logic [3:0] value,
    input  logic       borrow_in,
    output logic [3:0] next,
    output logic       borrow_out
);
    assign borrow_out = borrow_in && value == 4'd0;
    assign next = !borrow_in ? value : borrow_out ? WRAP : value - 4'd1;
endmodule

// File: rtl/timer_regressivo.sv
// timer_regressivo: keypad-loaded MM:SS BCD countdown with pause, clear and expiry pulse
module timer_regressivo
    import timer_regressivo_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clearn,
    input  logic       enable,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       zero,
    output logic       timer_done,
    output logic       running
);
    localparam int PW = $clog2(TICK_DIV);
    state_t state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [3:0][3:0] cnt, cnt_n, dec;
    logic [4:0] borrow;
    logic done_n, entry, counting, wrap;
    assign entry = digit_valid && digit <= BCD_MAX && state != RUN;
    assign counting = enable && state != IDLE;
    assign wrap = presc == PW'(TICK_DIV - 1);
    assign borrow[0] = wrap;
    // sec_tens wraps to 5 so 1:00 becomes 0:59; the other digits wrap to 9
    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit_down #(.WRAP(i == 1 ? 4'd5 : BCD_MAX)) u_digit (
            .value(cnt[i]),
            .borrow_in(borrow[i]),
            .next(dec[i]),
            .borrow_out(borrow[i+1])
        );
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        presc_n = presc;
        done_n = 1'b0;
        if (!clearn) begin
            state_n = IDLE;
            cnt_n = '0;
            presc_n = '0;
        end else if (entry) begin
            cnt_n = {cnt[2:0], digit};
            state_n = (cnt[2:0] != '0 || digit != 4'd0) ? SET : IDLE;
        end else if (counting) begin
            state_n = RUN;
            presc_n = wrap ? '0 : presc + 1'b1;
            // a borrow out of min_tens would mean underflow; never wrap 0000 to 99:59
            if (wrap && !borrow[4]) begin
                cnt_n = dec;
                if (dec == '0) begin
                    state_n = IDLE;
                    done_n = 1'b1;
                end
            end
        end else if (state == RUN) begin
            state_n = SET;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            presc <= '0;
            timer_done <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            presc <= presc_n;
            timer_done <= done_n;
        end
    end
    assign {min_tens, min_units, sec_tens, sec_units} = cnt;
    assign zero = cnt == '0;
    assign running = state == RUN;
endmodule
